regfile_dump_reader: RTL and testbench

//  Read-side sequencer for the 32x32 integer register file. On a start

---
 rtl/regfile_dump_reader.sv | 174 +++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
//   Read-side sequencer for the integer register file. A start command walks
//   an inclusive, wrapping index range through one regfile read port and
//   streams each value out over a valid/ready interface. The block is used
//   for debug and trap context dumps. The core is stalled while busy is high,
//   and the block owns the read port for the whole dump.
//
//   Optional feature macro: DUMP_CHECKSUM_EN
//     When defined, a running sum of all data beats is kept. After the last
//     register beat, one extra checksum beat is sent (out_is_csum=1).
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, abort          begin a dump (IDLE only) / cancel a running dump
//   first_reg, last_reg   inclusive index range, latched on accepted start
//   rf_ra, rf_rd          regfile read address / combinational read data
//   out_valid/out_ready   output handshake
//   out_data, out_idx     beat payload and its register index
//   out_last, out_is_csum final-beat flag / checksum-beat flag
//   busy, done            state != IDLE / one-cycle completion pulse
// ---------------------------------------------------------------------------
module regfile_dump_reader #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            abort,
   input  logic [AW-1:0]   first_reg,
   input  logic [AW-1:0]   last_reg,
   output logic [AW-1:0]   rf_ra,
   input  logic [XLEN-1:0] rf_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [AW-1:0]   out_idx,
   output logic            out_last,
   output logic            out_is_csum,
   output logic            busy,
   output logic            done
);

`ifdef DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_READ, S_HOLD, S_CSUM, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;
`endif

   state_t        state;
   logic [AW-1:0] idx;
   logic [AW-1:0] last_q;
   logic [AW-1:0] idx_nxt;
   logic          hs;
   logic          at_last;

`ifdef DUMP_CHECKSUM_EN
   logic [XLEN-1:0] sum;
   logic            csum_q;
   assign out_is_csum = csum_q;
`else
   assign out_is_csum = 1'b0;
`endif

   assign hs      = out_valid && out_ready;
   assign at_last = (idx == last_q);
   // Explicit wrap so a non power-of-two NREGS still walks modulo NREGS.
   assign idx_nxt = (idx == AW'(NREGS - 1)) ? '0 : idx + 1'b1;

   // The read port always points at the current index; in IDLE it simply
   // keeps the last index walked.
   assign rf_ra = idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         last_q    <= '0;
         out_data  <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         sum       <= '0;
         csum_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (abort && state != S_IDLE) begin
            // Abort wins over a same-cycle handshake: the beat is dropped.
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     idx    <= first_reg;
                     last_q <= last_reg;
                     busy   <= 1'b1;
                     state  <= S_READ;
`ifdef DUMP_CHECKSUM_EN
                     sum    <= '0;
`endif
                  end
               end
               S_READ: begin
                  // x0 is hardwired zero regardless of what the array holds.
                  out_data  <= (idx == '0) ? '0 : rf_rd;
                  out_idx   <= idx;
                  out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                  out_last  <= 1'b0;
                  csum_q    <= 1'b0;
`else
                  out_last  <= at_last;
`endif
                  state     <= S_HOLD;
               end
               S_HOLD: begin
                  if (hs) begin
                     out_valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                     sum       <= sum + out_data;
`endif
                     if (at_last) begin
`ifdef DUMP_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        done  <= 1'b1;
                        state <= S_DONE;
`endif
                     end else begin
                        idx   <= idx_nxt;
                        state <= S_READ;
                     end
                  end
               end
`ifdef DUMP_CHECKSUM_EN
               S_CSUM: begin
                  // First cycle presents the checksum beat, then wait for it
                  // to be taken.
                  if (!out_valid) begin
                     out_data  <= sum;
                     out_idx   <= last_q;
                     out_last  <= 1'b1;
                     csum_q    <= 1'b1;
                     out_valid <= 1'b1;
                  end else if (hs) begin
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end
               end
`endif
               S_DONE: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
`timescale 1ns/1ps
module tb_regfile_dump_reader;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            reset_n = 1'b1;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic            out_ready = 1'b1;
   logic [AW-1:0]   first_reg = '0;
   logic [AW-1:0]   last_reg = '0;
   logic [AW-1:0]   rf_ra;
   logic [AW-1:0]   out_idx;
   logic [XLEN-1:0] rf_rd;
   logic [XLEN-1:0] out_data;
   logic            out_valid, out_last, out_is_csum, busy, done;

   logic [XLEN-1:0] rf [NREGS];
   assign rf_rd = rf[rf_ra];

   regfile_dump_reader #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .first_reg(first_reg), .last_reg(last_reg), .rf_ra(rf_ra), .rf_rd(rf_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .out_is_csum(out_is_csum),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] data;
      logic            last;
      logic            csum;
      int              cyc;
   } beat_t;

   beat_t exp_q[$];
   beat_t log_q[$];

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Expected beat list straight from the range rules.
   task automatic build(input logic [AW-1:0] f, input logic [AW-1:0] l);
      logic [AW-1:0]   d;
      logic [XLEN-1:0] s;
      int              n;
      beat_t           b;
      d = l - f;
      n = int'(d) + 1;
      s = '0;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         b.idx  = AW'((int'(f) + k) % NREGS);
         b.data = (b.idx == '0) ? '0 : rf[b.idx];
         b.last = (k == n - 1);
         b.csum = 1'b0;
         b.cyc  = 0;
         s      = s + b.data;
`ifdef DUMP_CHECKSUM_EN
         b.last = 1'b0;
`endif
         exp_q.push_back(b);
      end
`ifdef DUMP_CHECKSUM_EN
      b.idx  = l;
      b.data = s;
      b.last = 1'b1;
      b.csum = 1'b1;
      exp_q.push_back(b);
`endif
   endtask

   // Model: idle / active / done-pulse, beats every time 2 cycles have passed
   // since start or since the previous accepted beat.
   typedef enum {M_IDLE, M_ACT, M_DONE} mst_t;
   mst_t            m_st = M_IDLE;
   int              m_gap = 0;
   int              done_cyc = -1;
   int              done_cnt = 0;
   int              start_cyc = -1;
   bit              p_hold = 1'b0;
   logic [XLEN-1:0] p_data;
   logic [AW-1:0]   p_idx;
   logic            p_last;
   beat_t           mb, la;

   always @(negedge clk) begin
      if (!reset_n) begin
         chk(!out_valid && !busy && !done && out_data == '0 && out_idx == '0 &&
             !out_last && !out_is_csum && rf_ra == '0, "reset_outputs",
             {22'b0, out_valid, busy, done, out_last, out_is_csum, out_idx} | out_data, 32'h0);
         m_st = M_IDLE;
         exp_q.delete();
         p_hold = 1'b0;
         m_gap = 0;
      end else begin
         chk(busy == (m_st != M_IDLE), "busy", 32'(busy), 32'(m_st != M_IDLE));
         chk(done == (m_st == M_DONE), "done", 32'(done), 32'(m_st == M_DONE));
         if (m_st == M_DONE) begin
            done_cyc = cyc;
            done_cnt++;
         end
         if (m_st == M_ACT) m_gap++;
         chk(out_valid == (m_st == M_ACT && m_gap >= 2), "out_valid", 32'(out_valid),
             32'(m_st == M_ACT && m_gap >= 2));
         if (m_st == M_ACT && !out_valid && exp_q.size() > 0 && !exp_q[0].csum)
            chk(rf_ra == exp_q[0].idx, "rf_ra", 32'(rf_ra), 32'(exp_q[0].idx));
         if (p_hold)
            chk(out_valid && out_data == p_data && out_idx == p_idx && out_last == p_last,
                "hold_stable", out_data, p_data);
         p_hold = 1'b0;
         case (m_st)
            M_IDLE: begin
               if (start) begin
                  build(first_reg, last_reg);
                  m_st = M_ACT;
                  m_gap = 0;
                  start_cyc = cyc;
               end
            end
            M_ACT: begin
               if (abort) begin
                  exp_q.delete();
                  m_st = M_IDLE;
               end else if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     chk(1'b0, "beat_extra", 32'(out_idx), 32'h0);
                  end else begin
                     mb = exp_q.pop_front();
                     chk(out_data == mb.data, "beat_data", out_data, mb.data);
                     chk(out_idx == mb.idx, "beat_idx", 32'(out_idx), 32'(mb.idx));
                     chk(out_last == mb.last, "beat_last", 32'(out_last), 32'(mb.last));
                     chk(out_is_csum == mb.csum, "beat_csum", 32'(out_is_csum), 32'(mb.csum));
                  end
                  la.idx = out_idx; la.data = out_data; la.last = out_last;
                  la.csum = out_is_csum; la.cyc = cyc;
                  log_q.push_back(la);
                  m_gap = 0;
                  if (exp_q.size() == 0) m_st = M_DONE;
               end else if (out_valid) begin
                  p_hold = 1'b1;
                  p_data = out_data;
                  p_idx  = out_idx;
                  p_last = out_last;
               end
            end
            default: m_st = M_IDLE;
         endcase
      end
   end

   // ---------------- driver ----------------
   bit rnd_ready = 1'b0;
   bit fix_ready = 1'b1;

   task automatic step();
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fix_ready;
   endtask

   task automatic fill_rf();
      for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
   endtask

   task automatic go(input logic [AW-1:0] f, input logic [AW-1:0] l);
      first_reg = f;
      last_reg  = l;
      start     = 1'b1;
      step();
      first_reg = AW'($urandom);
      last_reg  = AW'($urandom);
   endtask

   task automatic wait_idle(input bit chaos);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         if (chaos) begin
            if ($urandom_range(0, 3) == 0) start = 1'b1;
            if ($urandom_range(0, 39) == 0) abort = 1'b1;
         end
         step();
         n++;
      end
      chk(!busy, "idle_timeout", 32'(busy), 32'h0);
   endtask

   task automatic wait_valid(input logic [AW-1:0] want, input bit any);
      int n;
      n = 0;
      while (!(out_valid && (any || out_idx == want)) && n < 200) begin
         step();
         n++;
      end
      chk(out_valid, "valid_timeout", 32'(out_valid), 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   int d0;

   initial begin
      fill_rf();
      #1 reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();

      // 1: basic range with literal expectations and timing
      rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
      log_q.delete();
      go(5'd1, 5'd3);
      wait_idle(1'b0);
`ifndef DUMP_CHECKSUM_EN
      chk(log_q.size() == 3, "t1_count", 32'(log_q.size()), 32'd3);
      if (log_q.size() == 3) begin
         chk(log_q[0].idx == 5'd1 && log_q[0].data == 32'h11 && !log_q[0].last, "t1_beat0", log_q[0].data, 32'h11);
         chk(log_q[1].idx == 5'd2 && log_q[1].data == 32'h22 && !log_q[1].last, "t1_beat1", log_q[1].data, 32'h22);
         chk(log_q[2].idx == 5'd3 && log_q[2].data == 32'h33 && log_q[2].last, "t1_beat2", log_q[2].data, 32'h33);
         chk(log_q[0].cyc - start_cyc == 2, "t1_latency", 32'(log_q[0].cyc - start_cyc), 32'd2);
         chk(log_q[1].cyc - log_q[0].cyc == 2, "t1_rate", 32'(log_q[1].cyc - log_q[0].cyc), 32'd2);
         chk(done_cyc - log_q[2].cyc == 1, "t1_done_time", 32'(done_cyc - log_q[2].cyc), 32'd1);
      end
`endif
      step();

      // 2: wrap 30..1 with garbage behind x0
      rf[0] = 32'hBAD0_0BAD;
      log_q.delete();
      go(5'd30, 5'd1);
      wait_idle(1'b0);
`ifndef DUMP_CHECKSUM_EN
      chk(log_q.size() == 4, "t2_count", 32'(log_q.size()), 32'd4);
      if (log_q.size() == 4) begin
         chk(log_q[0].idx == 5'd30 && log_q[1].idx == 5'd31 && log_q[2].idx == 5'd0 &&
             log_q[3].idx == 5'd1, "t2_order", 32'(log_q[2].idx), 32'd0);
         chk(log_q[2].data == 32'h0, "t2_x0_zero", log_q[2].data, 32'h0);
      end
`endif
      step();

      // 3: stall beat 2 for 5 cycles
      log_q.delete();
      go(5'd5, 5'd8);
      wait_valid(5'd6, 1'b0);
      out_ready = 1'b0;
      fix_ready = 1'b0;
      repeat (5) step();
      fix_ready = 1'b1;
      out_ready = 1'b1;
      wait_idle(1'b0);
      chk(log_q.size() >= 4, "t3_count", 32'(log_q.size()), 32'd4);
      if (log_q.size() >= 2)
         chk(log_q[1].cyc - log_q[0].cyc == 7, "t3_stall_gap", 32'(log_q[1].cyc - log_q[0].cyc), 32'd7);
      step();

      // 4: abort in HOLD with ready high
      d0 = done_cnt;
      go(5'd10, 5'd12);
      wait_valid(5'd0, 1'b1);
      abort = 1'b1;
      out_ready = 1'b1;
      step();
      chk(!out_valid && !busy, "t4_abort_idle", {30'b0, out_valid, busy}, 32'h0);
      step();
      chk(done_cnt == d0, "t4_no_done", 32'(done_cnt), 32'(d0));
      log_q.delete();
      go(5'd10, 5'd12);
      wait_idle(1'b0);
      chk(done_cnt == d0 + 1, "t4_restart_done", 32'(done_cnt), 32'(d0 + 1));
      step();

      // 5: start while busy, then async reset mid-dump
      go(5'd0, 5'd31);
      start = 1'b1; first_reg = 5'd3; last_reg = 5'd3;
      step();
      start = 1'b1;
      step();
      repeat (4) step();
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk(!out_valid && !busy && !done && out_data == '0 && out_idx == '0 && rf_ra == '0,
          "t5_async_reset", out_data | {26'b0, out_valid, busy, rf_ra}, 32'h0);
      step();
      reset_n = 1'b1;
      step();
      log_q.delete();
      go(5'd2, 5'd4);
      wait_idle(1'b0);
`ifndef DUMP_CHECKSUM_EN
      chk(log_q.size() == 3, "t5_after_reset", 32'(log_q.size()), 32'd3);
`endif
      step();

`ifdef DUMP_CHECKSUM_EN
      // 6: checksum wraps modulo 2^XLEN
      rf[1] = 32'hFFFF_FFFF; rf[2] = 32'h2;
      log_q.delete();
      go(5'd1, 5'd2);
      wait_idle(1'b0);
      chk(log_q.size() == 3, "t6_count", 32'(log_q.size()), 32'd3);
      if (log_q.size() == 3) begin
         chk(!log_q[1].last, "t6_reg_last", 32'(log_q[1].last), 32'h0);
         chk(log_q[2].data == 32'h1 && log_q[2].csum && log_q[2].last && log_q[2].idx == 5'd2,
             "t6_csum_beat", log_q[2].data, 32'h1);
      end
      step();
`endif

      // random dumps with random backpressure, stray starts and aborts
      rnd_ready = 1'b1;
      repeat (60) begin
         fill_rf();
         log_q.delete();
         go(AW'($urandom), AW'($urandom));
         wait_idle(1'b1);
         step();
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
